// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates rob stores, lsb loads and icache fetches onto an 8-bit RAM/UART bus.
// Read of N bytes: ready in A+N+2; write of N bytes: ready in A+N+1 plus UART stall cycles; rdy_in low freezes everything.
module mem_ctrl #(
  parameter int ROB_SIZE_WIDTH = 4,
  parameter int IC_LINE_BYTES  = 4
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       io_buffer_full,
  input  logic [7:0]                 byte_dout,
  output logic [7:0]                 byte_din,
  output logic [31:0]                byte_a,
  output logic                       byte_wr,
  input  logic                       rob_clear,
  input  logic                       ic_valid,
  input  logic [31:0]                ic_addr,
  output logic                       ic_ready,
  output logic [IC_LINE_BYTES*8-1:0] ic_data,
  input  logic                       rob_valid,
  input  logic [31:0]                rob_addr,
  input  logic [31:0]                rob_data,
  input  logic [1:0]                 rob_size,
  output logic                       rob_ready,
  input  logic                       lsb_valid,
  input  logic [31:0]                lsb_addr,
  input  logic [1:0]                 lsb_size,
  input  logic                       lsb_signed,
  input  logic [ROB_SIZE_WIDTH-1:0]  lsb_dep,
  output logic                       lsb_ready,
  output logic [31:0]                lsb_data,
  output logic [ROB_SIZE_WIDTH-1:0]  lsb_dep_out
);

  localparam int LW = IC_LINE_BYTES * 8;
  localparam int IW = $clog2(IC_LINE_BYTES) + 1;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t                    state, state_nxt;
  logic [31:0]               addr_q, data_q, a_cur, a_last, idx_ext, ld_res, lo;
  logic [IW-1:0]             n_q, idx;
  logic                      is_ic_q, signed_q;
  logic [ROB_SIZE_WIDTH-1:0] dep_q;
  logic [LW-1:0]             line_q, line_nxt;
  logic                      take_rob, take_lsb, take_ic, done, stall, wr_en;

  function automatic logic [IW-1:0] size_to_n(input logic [1:0] sz);
    if (sz == 2'd0) return IW'(1);
    else if (sz == 2'd1) return IW'(2);
    else return IW'(4);
  endfunction

  assign idx_ext = {{(32-IW){1'b0}}, idx};

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else if (rdy_in) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take_rob  = 1'b0;
    take_lsb  = 1'b0;
    take_ic   = 1'b0;
    done      = 1'b0;
    stall     = 1'b0;
    wr_en     = 1'b0;
    a_cur     = '0;
    case (state)
      IDLE: begin
        // A channel still showing its ready pulse is the one just served.
        if (rob_valid && !rob_ready) begin
          take_rob  = 1'b1;
          state_nxt = WRITE;
        end else if (!rob_clear && lsb_valid && !lsb_ready) begin
          take_lsb  = 1'b1;
          state_nxt = READ;
        end else if (!rob_clear && ic_valid && !ic_ready) begin
          take_ic   = 1'b1;
          state_nxt = READ;
        end
      end
      READ: begin
        if (idx != n_q) a_cur = addr_q + idx_ext;
        if (rob_clear) begin
          state_nxt = IDLE;
        end else if (idx == n_q) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      WRITE: begin
        a_cur = addr_q + idx_ext;
        stall = (a_cur[17:16] == 2'b11) && io_buffer_full;
        wr_en = !stall;
        if (!stall && idx == n_q - IW'(1)) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // While frozen, keep driving the last presented address so the RAM re-reads the pending byte.
  assign byte_a   = rdy_in ? a_cur : a_last;
  assign byte_wr  = rdy_in & wr_en;
  assign byte_din = (state == WRITE) ? data_q[{idx[1:0], 3'b000} +: 8] : 8'h00;

  always_comb begin
    line_nxt = line_q;
    for (int i = 0; i < IC_LINE_BYTES; i++) begin
      if (idx == IW'(i + 1)) line_nxt[i*8 +: 8] = byte_dout;
    end
  end

  always_comb begin
    lo = line_nxt[31:0];
    if (n_q == IW'(1)) ld_res = {{24{signed_q & lo[7]}}, lo[7:0]};
    else if (n_q == IW'(2)) ld_res = {{16{signed_q & lo[15]}}, lo[15:0]};
    else ld_res = lo;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      addr_q      <= '0;
      data_q      <= '0;
      n_q         <= '0;
      idx         <= '0;
      is_ic_q     <= 1'b0;
      signed_q    <= 1'b0;
      dep_q       <= '0;
      line_q      <= '0;
      a_last      <= '0;
      rob_ready   <= 1'b0;
      lsb_ready   <= 1'b0;
      ic_ready    <= 1'b0;
      ic_data     <= '0;
      lsb_data    <= '0;
      lsb_dep_out <= '0;
    end else if (rdy_in) begin
      a_last    <= a_cur;
      rob_ready <= 1'b0;
      lsb_ready <= 1'b0;
      ic_ready  <= 1'b0;
      if (take_rob) begin
        addr_q <= rob_addr;
        data_q <= rob_data;
        n_q    <= size_to_n(rob_size);
        idx    <= '0;
      end
      if (take_lsb) begin
        addr_q   <= lsb_addr;
        n_q      <= size_to_n(lsb_size);
        signed_q <= lsb_signed;
        dep_q    <= lsb_dep;
        is_ic_q  <= 1'b0;
        idx      <= '0;
        line_q   <= '0;
      end
      if (take_ic) begin
        addr_q  <= ic_addr;
        n_q     <= IW'(IC_LINE_BYTES);
        is_ic_q <= 1'b1;
        idx     <= '0;
        line_q  <= '0;
      end
      if (state == READ && !rob_clear) begin
        line_q <= line_nxt;
        if (idx != n_q) idx <= idx + IW'(1);
        if (done) begin
          if (is_ic_q) begin
            ic_data  <= line_nxt;
            ic_ready <= 1'b1;
          end else begin
            lsb_data    <= ld_res;
            lsb_dep_out <= dep_q;
            lsb_ready   <= 1'b1;
          end
        end
      end
      if (state == WRITE && !stall) begin
        idx <= idx + IW'(1);
        if (done) rob_ready <= 1'b1;
      end
    end
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller between the out-of-order core and the single-port 8-bit RAM/UART bus. Arbitrates instruction-cache line fetches, LSB loads and ROB-committed stores. Sequences each request into 1..IC_LINE_BYTES single-byte RAM cycles, assembles little-endian results with optional sign extension, and returns them through per-channel ready pulses. Adds UART back-pressure, flush of speculative reads and configurable fetch width.

## Interface
- ROB_SIZE_WIDTH, 4, width of the load dependency tag.
- IC_LINE_BYTES, 4, bytes per instruction fetch. Power of two, 4..64.
- clk_in  in  1  clock.
- rst_in  in  1  synchronous, active-high reset.
- rdy_in  in  1  global enable. Low freezes all state and forces byte_wr=0.
- io_buffer_full  in  1  UART transmit buffer full.
- byte_dout  in  8  RAM read data. Valid one cycle after its address.
- byte_din  out  8  RAM write data.
- byte_a  out  32  RAM byte address.
- byte_wr  out  1  1 = write, 0 = read.
- rob_clear  in  1  pipeline flush.
- ic_valid  in  1  fetch request.
- ic_addr  in  32  fetch start address.
- ic_ready  out  1  one-cycle pulse: ic_data valid.
- ic_data  out  IC_LINE_BYTES*8  fetched line, byte 0 in bits [7:0].
- rob_valid  in  1  store request.
- rob_addr  in  32  store address.
- rob_data  in  32  store data.
- rob_size  in  2  store size: 0 byte, 1 half, 2/3 word.
- rob_ready  out  1  one-cycle pulse: store complete.
- lsb_valid  in  1  load request.
- lsb_addr  in  32  load address.
- lsb_size  in  2  load size: 0 byte, 1 half, 2/3 word.
- lsb_signed  in  1  sign-extend the load result.
- lsb_dep  in  ROB_SIZE_WIDTH  ROB tag of the load.
- lsb_ready  out  1  one-cycle pulse: load result valid.
- lsb_data  out  32  load result.
- lsb_dep_out  out  ROB_SIZE_WIDTH  tag returned with lsb_data.

## Operation
- FSM states: IDLE, READ, WRITE.
- Reset: state IDLE; all ready outputs 0; ic_data, lsb_data, lsb_dep_out, byte_din, byte_a all 0; byte_wr 0.
- Arbitration in IDLE uses fixed priority: rob > lsb > ic.
  - A channel whose ready output is high in the current cycle is masked out.
  - While rob_clear is high, lsb and ic are not accepted; rob may still be accepted.
- Acceptance latches the channel's address, data, size, signed flag and tag, and sets the byte count N:
  - rob/lsb: N = 1, 2 or 4 from the size field.
  - ic: N = IC_LINE_BYTES.
- Requester holds valid and its fields stable until its ready pulse. It must drop valid no later than the cycle after the pulse.
- READ:
  - Presents addresses addr+0..addr+N-1 on consecutive cycles with byte_wr=0.
  - Captures byte_dout one cycle after each address into byte lane i.
  - After the last capture, the ready pulse is asserted and the FSM returns to IDLE.
- Load result:
  - Bytes are zero-filled above N.
  - If lsb_signed, bit 8N-1 is replicated upward.
  - lsb_dep_out = latched tag.
- WRITE: presents addr+i with byte_din = rob_data[8i+7:8i] and byte_wr=1 for i = 0..N-1, then pulses rob_ready and returns to IDLE.
- UART back-pressure: in WRITE, if the current address has addr[17:16]==2'b11 and io_buffer_full=1:
  - byte_wr=0;
  - the byte index holds;
  - the byte is retried every cycle until io_buffer_full=0.
- Misaligned addresses are legal and are handled as plain sequential bytes. Address arithmetic is 32-bit modulo 2^32.
- rob_clear during READ:
  - The in-flight load or fetch is abandoned and the FSM is IDLE the next cycle.
  - No ready pulse is produced for it.
  - A ready pulse for lsb/ic that would fire in the cycle after rob_clear is suppressed.
- rob_clear during WRITE has no effect; the committed store completes.
- IDLE outputs: byte_wr=0, byte_a=0.

## Timing
- Acceptance cycle A is the IDLE cycle in which valid is sampled.
- READ:
  - Byte i address is presented in cycle A+1+i.
  - Data returns in A+2+i.
  - Ready is high in cycle A+N+2.
  - Word load: 6 cycles from A to ready. Byte load: 3. IC_LINE_BYTES=16: 18.
- WRITE:
  - Bytes are written in A+1..A+N.
  - rob_ready is high in A+N+1, plus one cycle per back-pressure stall cycle.
- The next acceptance can occur in the ready cycle (other channels only); back-to-back requests therefore have zero idle gap.
- rdy_in=0 for k cycles delays every event above by k.
  - byte_a holds, byte_wr=0.
  - Captures pause; the RAM re-presents the held address, so the pending byte is re-read on resume.
- Ready outputs are registered and are high for exactly one enabled cycle.
- Reset asserted mid-operation: outputs take reset values next cycle; the transaction is lost with no ready pulse.

## Test plan
- Word load, signed:
  - Stimulus: RAM[0x100..0x103] = 0x80,0x00,0x00,0xF0; lsb_valid with addr 0x100, size 2, lsb_dep 5.
  - Required: lsb_ready 6 cycles after acceptance; lsb_data 0xF0000080; lsb_dep_out 5.
- Byte load sign/zero extension: RAM[0x200] = 0x9C. Signed load returns 0xFFFFFF9C; unsigned load returns 0x0000009C; each 3 cycles after acceptance.
- Half store then fetch:
  - Half store 0xBEEF to 0x302 writes 0xEF then 0xBE; rob_ready 3 cycles after acceptance.
  - Fetch at 0x300 with IC_LINE_BYTES=4 returns ic_data[31:16] = 0xBEEF.
- Simultaneous rob, lsb and ic requests: served in order rob, lsb, ic; each ready pulse lasts one cycle; no request is served twice.
- UART store: byte store to 0x30000 with io_buffer_full high for 3 cycles. byte_wr stays 0 during those cycles, then a single write occurs; rob_ready 5 cycles after acceptance.
- Flush and freeze:
  - rob_clear in the cycle after a word-load acceptance: no lsb_ready; FSM idle; a pending ic request is accepted 2 cycles later.
  - rdy_in low for 2 cycles mid-load: result unchanged, arriving 2 cycles late.
